// File: rtl/hit_stat_pkg.sv
// Shared types and constants for the hit-statistic scan sequencer.
package hit_stat_pkg;

  localparam int COUNT_W   = 20;
  localparam int TIMEOUT_W = 32;

  // State encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FIND   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_ARM    = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_PUSH   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FIND   = ST_FIND,
    S_SETTLE = ST_SETTLE,
    S_START  = ST_START,
    S_ARM    = ST_ARM,
    S_WAIT   = ST_WAIT,
    S_PUSH   = ST_PUSH,
    S_DONE   = ST_DONE
  } state_t;

  // Captured measurement (channel index is width-parameterized, kept outside)
  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic               over;
    logic               timeout;
  } stat_res_t;

endpackage

// File: rtl/hit_scan_timeout.sv
// Window timeout counter: cleared at stat_start, counts while enabled,
// saturates once the limit is reached.
module hit_scan_timeout
  import hit_stat_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic clk40M,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q >= LAST);

  // Next count: clear wins, otherwise count up until expired
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  // Count register
  always_ff @(posedge clk40M) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hit_scan_sequencer.sv
// Scans enabled hit channels through one shared hit-statistic counter and
// streams {channel, count, over, timeout} results on a valid/ready port.
module hit_scan_sequencer
  import hit_stat_pkg::*;
#(
  parameter int          NUM_CH      = 16,
  parameter int          CH_W        = 4,
  parameter int          SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic               clk40M,
  input  logic               reset,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [COUNT_W-1:0] threshold,
  output logic               busy,
  output logic               done,
  output logic [CH_W-1:0]    hit_sel,
  output logic               stat_start,
  input  logic               stat_ready,
  input  logic [COUNT_W-1:0] stat_count,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CH_W-1:0]    res_channel,
  output logic [COUNT_W-1:0] res_count,
  output logic               res_over,
  output logic               res_timeout
);

  localparam int             SET_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CH_W:0]  CH_END      = (CH_W+1)'(NUM_CH);

  state_t             state_q, state_d;
  logic               start_q;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [COUNT_W-1:0] thr_q, thr_d;
  logic [CH_W:0]      ch_q, ch_d;        // one extra bit to run past the last channel
  logic [CH_W-1:0]    hit_sel_q, hit_sel_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               abort_q, abort_d;  // abort seen while a result is pending
  logic               res_valid_q, res_valid_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  stat_res_t          res_q, res_d;
  logic               to_clr, to_en, to_expired;
  logic               start_rise;

  assign start_rise  = cmd_start & ~start_q;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign stat_start  = (state_q == S_START);
  assign hit_sel     = hit_sel_q;
  assign res_valid   = res_valid_q;
  assign res_channel = res_ch_q;
  assign res_count   = res_q.count;
  assign res_over    = res_q.over;
  assign res_timeout = res_q.timeout;

  hit_scan_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk40M    (clk40M),
    .reset     (reset),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  // Scan FSM next state and datapath updates
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    thr_d       = thr_q;
    ch_d        = ch_q;
    hit_sel_d   = hit_sel_q;
    settle_d    = settle_q;
    abort_d     = abort_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_d       = res_q;
    to_clr      = 1'b0;
    to_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start_rise) begin
          mask_d  = ch_mask;
          thr_d   = threshold;
          ch_d    = '0;
          state_d = S_FIND;
        end
      end
      S_FIND: begin
        if (cmd_abort || ch_q >= CH_END) begin
          state_d = S_DONE;
        end else if (mask_q[ch_q[CH_W-1:0]]) begin
          hit_sel_d = ch_q[CH_W-1:0];
          settle_d  = '0;
          state_d   = S_SETTLE;
        end else begin
          ch_d = ch_q + (CH_W+1)'(1);
        end
      end
      S_SETTLE: begin
        if (cmd_abort)                   state_d  = S_DONE;
        else if (settle_q == SETTLE_LAST) state_d  = S_START;
        else                             settle_d = settle_q + SET_W'(1);
      end
      S_START: begin
        to_clr  = 1'b1;
        state_d = cmd_abort ? S_DONE : S_ARM;
      end
      S_ARM, S_WAIT: begin
        to_en = 1'b1;
        if (cmd_abort) begin
          state_d = S_DONE;
        end else if (state_q == S_WAIT && stat_ready) begin
          // A fresh window completed: take the real count
          res_d.count   = stat_count;
          res_d.over    = (stat_count >= thr_q);
          res_d.timeout = 1'b0;
          res_ch_d      = ch_q[CH_W-1:0];
          res_valid_d   = 1'b1;
          state_d       = S_PUSH;
        end else if (to_expired) begin
          res_d.count   = '0;
          res_d.over    = 1'b0;
          res_d.timeout = 1'b1;
          res_ch_d      = ch_q[CH_W-1:0];
          res_valid_d   = 1'b1;
          state_d       = S_PUSH;
        end else if (state_q == S_ARM && !stat_ready) begin
          // Stale ready from the previous window has dropped
          state_d = S_WAIT;
        end
      end
      S_PUSH: begin
        if (cmd_abort) abort_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (abort_q || cmd_abort) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + (CH_W+1)'(1);
            state_d = S_FIND;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk40M) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      mask_q      <= '0;
      thr_q       <= '0;
      ch_q        <= '0;
      hit_sel_q   <= '0;
      settle_q    <= '0;
      abort_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= cmd_start;
      mask_q      <= mask_d;
      thr_q       <= thr_d;
      ch_q        <= ch_d;
      hit_sel_q   <= hit_sel_d;
      settle_q    <= settle_d;
      abort_q     <= abort_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_q       <= res_d;
    end
  end

endmodule

// File: tb/tb_hit_scan_sequencer.sv
// Bench for hit_scan_sequencer: table of scan passes checked through a
// result scoreboard, plus hand-written timing / back-pressure / abort /
// timeout / reset sequences. A behavioural counter model answers stat_start.
module tb_hit_scan_sequencer;
  import hit_stat_pkg::*;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int TO_CYC = 50;
  localparam int LAT    = 6;   // model: cycles from stat_start to ready

  logic               clk40M = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_start = 1'b0;
  logic               cmd_abort = 1'b0;
  logic [NUM_CH-1:0]  ch_mask = '0;
  logic [COUNT_W-1:0] threshold = '0;
  logic               busy, done, stat_start, res_valid, res_over, res_timeout;
  logic [CH_W-1:0]    hit_sel, res_channel;
  logic               stat_ready = 1'b0;
  logic [COUNT_W-1:0] stat_count = '0;
  logic               res_ready = 1'b1;
  logic [COUNT_W-1:0] res_count;

  hit_scan_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYC(4), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk40M(clk40M), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .ch_mask(ch_mask), .threshold(threshold), .busy(busy), .done(done),
    .hit_sel(hit_sel), .stat_start(stat_start), .stat_ready(stat_ready),
    .stat_count(stat_count), .res_valid(res_valid), .res_ready(res_ready),
    .res_channel(res_channel), .res_count(res_count), .res_over(res_over),
    .res_timeout(res_timeout)
  );

  always #12 clk40M = ~clk40M;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [COUNT_W-1:0] cnt;
    logic               over;
    logic               to;
  } exp_t;

  typedef struct {
    logic [NUM_CH-1:0]       mask;
    logic [COUNT_W-1:0]      thr;
    int                      n;
    logic [2:0][COUNT_W-1:0] cnt;   // counts the model returns, in scan order
    logic [2:0][CH_W-1:0]    ech;   // expected channels
    logic [2:0]              eover; // expected over flags
  } vec_t;

  exp_t               exp_q[$];
  logic [COUNT_W-1:0] model_q[$];
  bit                 model_never = 1'b0;
  int                 total = 0, bad = 0;
  int                 done_cnt = 0, ss_cnt = 0;
  logic               done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Counter model: clears ready 2 cycles after start, returns a count after LAT
  int   age = 0;
  bit   armed = 1'b0;
  logic [COUNT_W-1:0] pend;
  always @(negedge clk40M) begin
    if (armed) begin
      age++;
      if (age == 2) stat_ready = 1'b0;
      if (age == LAT && !model_never) begin
        stat_ready = 1'b1;
        stat_count = pend;
        armed      = 1'b0;
      end
    end
    if (stat_start) begin
      armed = 1'b1;
      age   = 0;
      pend  = (model_q.size() > 0) ? model_q.pop_front() : '0;
    end
  end

  // Result scoreboard and done-pulse monitor
  always @(negedge clk40M) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result actual=ch%0d/%0h required=none", res_channel, res_count);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({res_channel, res_count, res_over, res_timeout}), 32'(e));
      end
    end
    if (done && done_prev) begin
      total++; bad++;
      $display("FAIL done_width actual=2+cycles required=1");
    end
    done_prev = done;
    if (done) done_cnt++;
    if (stat_start) ss_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk40M);
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m, input logic [COUNT_W-1:0] t);
    ch_mask = m; threshold = t; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_sig_start(input string name);
    int n = 0;
    while (!stat_start && n < 200) begin tick(); n++; end
    check({name, "_stat_start"}, 32'(stat_start), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int   n;
    int   d0, s0;
    bit   ok;
    logic [31:0] snap;

    // mask, thr, n, counts, channels, over
    vecs[0] = '{16'h0005, 20'd10,     2, {20'd0, 20'd3,  20'd12},     {4'd0, 4'd2,  4'd0},  3'b001};
    vecs[1] = '{16'h8000, 20'hFFFFF,  1, {20'd0, 20'd0,  20'hFFFFF},  {4'd0, 4'd0,  4'd15}, 3'b001};
    vecs[2] = '{16'h0402, 20'd100,    2, {20'd0, 20'd99, 20'd100},    {4'd0, 4'd10, 4'd1},  3'b001};
    vecs[3] = '{16'h8001, 20'd0,      2, {20'd0, 20'd5,  20'd0},      {4'd0, 4'd15, 4'd0},  3'b011};
    vecs[4] = '{16'h0000, 20'd7,      0, {20'd0, 20'd0,  20'd0},      {4'd0, 4'd0,  4'd0},  3'b000};

    // Reset state
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_ctrl", 32'({busy, done, stat_start, res_valid}), 32'd0);
    check("rst_hit_sel", 32'(hit_sel), 32'd0);
    check("rst_res", 32'({res_channel, res_count, res_over, res_timeout}), 32'd0);

    // Table-driven scan passes
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        model_q.push_back(vecs[i].cnt[k]);
        exp_q.push_back('{ch: vecs[i].ech[k], cnt: vecs[i].cnt[k], over: vecs[i].eover[k], to: 1'b0});
      end
      d0 = done_cnt;
      pulse_start(vecs[i].mask, vecs[i].thr);
      wait_done($sformatf("vec%0d", i), n);
      tick();
      check($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_ndone", i), 32'(done_cnt - d0), 32'd1);
      tick(3);
    end

    // Empty mask: done NUM_CH+1 cycles after the first FIND cycle
    pulse_start('0, 20'd1);
    wait_done("empty", n);
    check("empty_latency", 32'(n), 32'(NUM_CH + 1));
    tick(3);

    // Back-pressure: result held 100 cycles, no new window started
    res_ready = 1'b0;
    model_q.push_back(20'd7); model_q.push_back(20'd2);
    exp_q.push_back('{ch: 4'd0, cnt: 20'd7, over: 1'b1, to: 1'b0});
    exp_q.push_back('{ch: 4'd1, cnt: 20'd2, over: 1'b0, to: 1'b0});
    pulse_start(16'h0003, 20'd5);
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    check("bp_valid", 32'(res_valid), 32'd1);
    snap = 32'({res_channel, res_count, res_over, res_timeout});
    s0 = ss_cnt;
    ok = 1'b1;
    repeat (100) begin
      tick();
      if (res_valid !== 1'b1 || 32'({res_channel, res_count, res_over, res_timeout}) !== snap) ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    check("bp_no_start", 32'(ss_cnt - s0), 32'd0);
    res_ready = 1'b1;
    wait_done("bp", n);
    tick();
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    tick(3);

    // Timeout: model never answers
    model_never = 1'b1;
    exp_q.push_back('{ch: 4'd0, cnt: 20'd0, over: 1'b0, to: 1'b1});
    pulse_start(16'h0001, 20'd0);
    wait_sig_start("to");
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    check("to_latency", 32'(n), 32'(TO_CYC + 1));
    wait_done("to", n);
    tick();
    check("to_drain", 32'(exp_q.size()), 32'd0);
    model_never = 1'b0;
    tick(3);

    // Abort while waiting for ready: done next cycle, no result
    model_q.push_back(20'd9);
    pulse_start(16'h0001, 20'd1);
    wait_sig_start("abort");
    tick(3);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_done", 32'(done), 32'd1);
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    tick(10);
    check("abort_no_result", 32'(res_valid), 32'd0);
    tick(3);

    // Reset while settling on channel 2: back to idle, no done
    pulse_start(16'h0004, 20'd1);
    tick(3);
    check("rst_mid_sel", 32'(hit_sel), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hit_sel", 32'(hit_sel), 32'd0);
    d0 = done_cnt;
    s0 = ss_cnt;
    tick(40);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_no_start", 32'(ss_cnt - s0), 32'd0);
    check("rst_mid_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
